pkt_encap_dfx: RTL and testbench
================================

Name: pkt_encap_dfx

Overview:
- Encapsulation stage directly downstream of the router controller.
- Absorbs payload words popped from input port 0 (the controller owns the FIFO read strobe) into a local skid buffer.
- Requests a fresh header via ready_encap_dfx, then emits one header flit followed by PAYLOAD_LEN payload flits on a valid/ready stream toward the crossbar/output port.

Parameters:
- ADDR_WIDTH, 10, width of destination router address.
- HEADER_WIDTH, 9, width of header {TTL[1:0], pkt_number[4:0], src_router[1:0]}.
- DATA_WIDTH, 32, flit width; must be >= ADDR_WIDTH+HEADER_WIDTH.
- PAYLOAD_LEN, 4, payload flits per packet (>=1).
- BUF_DEPTH, 8, skid buffer entries (power of 2, >= PAYLOAD_LEN).

Ports:
- clk  in  1  clock; single clock domain, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  DATA_WIDTH  payload word from input port 0.
- in_valid  in  1  in_data valid; one cycle after controller's rd_input_port_0; cannot be back-pressured.
- router_dst_addr_send  in  ADDR_WIDTH  destination address registered by the controller.
- header_pkt_send  in  HEADER_WIDTH  header registered by the controller.
- ready_encap_dfx  out  1  one-cycle header request pulse to the controller.
- flit_data  out  DATA_WIDTH  output flit.
- flit_valid  out  1  flit_data valid.
- flit_ready  in  1  downstream accepts flit when valid&ready.
- flit_sop  out  1  marks header flit.
- flit_eop  out  1  marks last flit of packet.
- buf_count  out  $clog2(BUF_DEPTH)+1  skid buffer occupancy.
- overflow  out  1  sticky: push while full.
- pkt_sent  out  16  packets completed, wraps 0xFFFF->0.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, buffer pointers/count=0. ready_encap_dfx, flit_valid, flit_sop, flit_eop, overflow = 0. flit_data=0, pkt_sent=0, captured header/dst=0. Reset mid-packet discards the partial packet; no flit emitted until a new request completes.
- Buffer: circular FIFO.
  - Push on in_valid; pop on payload flit handshake.
  - Simultaneous push+pop: count unchanged.
  - Push while full (count==BUF_DEPTH) without a same-cycle pop: data dropped, overflow set until reset.
  - Pointers wrap modulo BUF_DEPTH.
- FSM:
  - IDLE: when buf_count>=PAYLOAD_LEN -> REQ.
  - REQ: ready_encap_dfx=1 for exactly this cycle -> WAIT.
  - WAIT: controller updates its registers at the REQ edge; capture header_pkt_send and router_dst_addr_send at the end of this cycle -> HDR.
  - HDR: flit_valid=1, flit_sop=1.
    - flit_data = zero-extended {dst[ADDR_WIDTH-1:0], header[HEADER_WIDTH-1:0]}, header in LSBs.
    - Hold stable until flit_ready -> PAY, beat counter=0.
  - PAY: flit_valid=1, flit_data = buffer head (combinational from head entry).
    - Each handshake pops one word and increments the beat counter.
    - flit_eop=1 on beat PAYLOAD_LEN-1; handshake on it -> IDLE and pkt_sent+1.
- Payload availability: PAY is entered only with >=PAYLOAD_LEN words buffered and nothing else pops, so there is no underflow.
- Latency: with buffer pre-filled and flit_ready=1, the header flit is valid 3 cycles after IDLE sees the threshold (REQ, WAIT, HDR). Back-to-back packets have a 3-cycle gap.
- Stream rule: flit_data/sop/eop hold stable while flit_valid & !flit_ready. flit_valid never deasserts without a handshake.
- Simultaneous push into the buffer during PAY is always accepted if not full.

Optional Feature:
- Macro: PKT_CHECKSUM_EN.
- Defined:
  - After the last payload flit, FSM enters TRL and emits one trailer flit = XOR of all payload words of the packet, accumulated on pop handshakes and cleared in HDR.
  - flit_eop moves to the trailer; packet length is PAYLOAD_LEN+2 flits.
  - pkt_sent increments on the trailer handshake.
- Undefined: no TRL state or accumulator; eop on the last payload flit.

Test Plan:
- Reset mid-PAY: assert rst_n=0 after 2 payload beats -> all outputs 0 immediately, buf_count=0, next packet starts with a fresh REQ pulse.
- Basic packet: push 4 words 0x11,0x22,0x33,0x44; controller drives dst=0x2A5, header=9'h105 after request; flit_ready=1 -> exactly one ready_encap_dfx pulse, then flits 0x000547 05... more precisely {0x2A5,9'h105}=0x0054B05 sop, then 0x11,0x22,0x33,0x44 with eop on 0x44, pkt_sent=1.
- Back-pressure: same stimulus, flit_ready toggles 1,0,0,1 -> each flit held stable while stalled, no duplicate or lost words, order preserved.
- Overflow: push 9 words into BUF_DEPTH=8 with flit_ready=0 -> 9th dropped, overflow=1 sticky, buf_count=8.
- Simultaneous push/pop: stream in_valid every cycle during PAY with flit_ready=1 -> buf_count constant, two consecutive packets correct, pkt_sent=2.
- PKT_CHECKSUM_EN: payload 0x0F,0xF0,0xFF,0x01 -> trailer 0x01 with eop, payload flits have eop=0.

Source files
------------

// File: rtl/pkt_encap_dfx.sv
// Encapsulation stage: buffers input-port payload words, requests a header from the router
// controller, then streams header + PAYLOAD_LEN payload flits. Define PKT_CHECKSUM_EN for an XOR trailer.
module pkt_encap_dfx #(
    parameter int ADDR_WIDTH   = 10,
    parameter int HEADER_WIDTH = 9,
    parameter int DATA_WIDTH   = 32,
    parameter int PAYLOAD_LEN  = 4,
    parameter int BUF_DEPTH    = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_valid,
    input  logic [ADDR_WIDTH-1:0]       router_dst_addr_send,
    input  logic [HEADER_WIDTH-1:0]     header_pkt_send,
    output logic                        ready_encap_dfx,
    output logic [DATA_WIDTH-1:0]       flit_data,
    output logic                        flit_valid,
    input  logic                        flit_ready,
    output logic                        flit_sop,
    output logic                        flit_eop,
    output logic [$clog2(BUF_DEPTH):0]  buf_count,
    output logic                        overflow,
    output logic [15:0]                 pkt_sent
);
    localparam int PTR_W  = $clog2(BUF_DEPTH);
    localparam int CNT_W  = $clog2(BUF_DEPTH) + 1;
    localparam int BEAT_W = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;

`ifdef PKT_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HDR, S_PAY, S_TRL} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HDR, S_PAY} state_t;
`endif

    state_t                    state_q, state_d;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      overflow_q, overflow_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic [ADDR_WIDTH-1:0]     dst_q, dst_d;
    logic [HEADER_WIDTH-1:0]   hdr_q, hdr_d;
    logic [15:0]               pkt_sent_q, pkt_sent_d;
`ifdef PKT_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]     csum_q, csum_d;
`endif
    logic [DATA_WIDTH-1:0]     mem_q [BUF_DEPTH];
    logic                      full, pop, push_ok, last_beat;

    assign full      = (count_q == CNT_W'(BUF_DEPTH));
    assign pop       = (state_q == S_PAY) && flit_ready;
    // A full buffer still accepts a word when the head is leaving in the same cycle
    assign push_ok   = in_valid && (!full || pop);
    assign last_beat = (beat_q == BEAT_W'(PAYLOAD_LEN - 1));

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (in_valid & full & ~pop);
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        beat_d          = beat_q;
        dst_d           = dst_q;
        hdr_d           = hdr_q;
        pkt_sent_d      = pkt_sent_q;
        ready_encap_dfx = 1'b0;
        flit_valid      = 1'b0;
        flit_sop        = 1'b0;
        flit_eop        = 1'b0;
        flit_data       = '0;
`ifdef PKT_CHECKSUM_EN
        csum_d          = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (count_q >= CNT_W'(PAYLOAD_LEN)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                ready_encap_dfx = 1'b1;
                state_d         = S_WAIT;
            end
            S_WAIT: begin
                // Controller has refreshed its registers on the REQ edge
                dst_d   = router_dst_addr_send;
                hdr_d   = header_pkt_send;
                state_d = S_HDR;
            end
            S_HDR: begin
                flit_valid = 1'b1;
                flit_sop   = 1'b1;
                flit_data[ADDR_WIDTH+HEADER_WIDTH-1:0] = {dst_q, hdr_q};
`ifdef PKT_CHECKSUM_EN
                csum_d     = '0;
`endif
                if (flit_ready) begin
                    state_d = S_PAY;
                    beat_d  = '0;
                end
            end
            S_PAY: begin
                flit_valid = 1'b1;
                flit_data  = mem_q[rd_ptr_q];
`ifdef PKT_CHECKSUM_EN
                if (flit_ready) begin
                    csum_d = csum_q ^ mem_q[rd_ptr_q];
                    beat_d = beat_q + 1'b1;
                    if (last_beat) begin
                        state_d = S_TRL;
                    end
                end
`else
                flit_eop   = last_beat;
                if (flit_ready) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat) begin
                        state_d    = S_IDLE;
                        pkt_sent_d = pkt_sent_q + 16'd1;
                    end
                end
`endif
            end
`ifdef PKT_CHECKSUM_EN
            S_TRL: begin
                flit_valid = 1'b1;
                flit_eop   = 1'b1;
                flit_data  = csum_q;
                if (flit_ready) begin
                    state_d    = S_IDLE;
                    pkt_sent_d = pkt_sent_q + 16'd1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            beat_q     <= '0;
            dst_q      <= '0;
            hdr_q      <= '0;
            pkt_sent_q <= '0;
`ifdef PKT_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            beat_q     <= beat_d;
            dst_q      <= dst_d;
            hdr_q      <= hdr_d;
            pkt_sent_q <= pkt_sent_d;
`ifdef PKT_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign buf_count = count_q;
    assign overflow  = overflow_q;
    assign pkt_sent  = pkt_sent_q;

endmodule

// File: tb/tb_pkt_encap_dfx.sv
// Scoreboard bench for pkt_encap_dfx: header/payload queues filled as stimulus is driven,
// drained and compared by a negedge flit monitor. Honours PKT_CHECKSUM_EN.
module tb_pkt_encap_dfx;
    localparam int AW = 10, HW = 9, DW = 32, PL = 4, BD = 8;
`ifdef PKT_CHECKSUM_EN
    localparam int FLITS = PL + 2;
`else
    localparam int FLITS = PL + 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic [AW-1:0] router_dst_addr_send = '0;
    logic [HW-1:0] header_pkt_send = '0;
    logic          ready_encap_dfx;
    logic [DW-1:0] flit_data;
    logic          flit_valid, flit_sop, flit_eop;
    logic          flit_ready = 1'b0;
    logic [3:0]    buf_count;
    logic          overflow;
    logic [15:0]   pkt_sent;

    int tests_run = 0;
    int fail_cnt  = 0;

    logic [DW-1:0] pay_q[$];
    logic [DW-1:0] hdr_q[$];
    logic [AW-1:0] cur_dst = '0;
    logic [HW-1:0] cur_hdr = '0;
    int            req_pulses = 0, flits_seen = 0, stall_checks = 0;
    int            phase = 0, beat = 0;
    bit            pending_hdr = 0, prev_ready = 0, prev_stall = 0;
    logic [DW-1:0] csum = '0, last_trl = '0, mon_exp, prev_data;
    logic          mon_eop, prev_sop, prev_eop;

    pkt_encap_dfx #(
        .ADDR_WIDTH(AW), .HEADER_WIDTH(HW), .DATA_WIDTH(DW), .PAYLOAD_LEN(PL), .BUF_DEPTH(BD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .router_dst_addr_send(router_dst_addr_send), .header_pkt_send(header_pkt_send),
        .ready_encap_dfx(ready_encap_dfx), .flit_data(flit_data), .flit_valid(flit_valid),
        .flit_ready(flit_ready), .flit_sop(flit_sop), .flit_eop(flit_eop),
        .buf_count(buf_count), .overflow(overflow), .pkt_sent(pkt_sent)
    );

    always #5 clk = ~clk;

    // Controller model plus flit monitor, all sampled mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            pending_hdr = 0; prev_ready = 0; prev_stall = 0; phase = 0; beat = 0;
        end else begin
            if (pending_hdr) begin
                router_dst_addr_send = cur_dst;
                header_pkt_send      = cur_hdr;
                mon_exp              = '0;
                mon_exp[AW+HW-1:0]   = {cur_dst, cur_hdr};
                hdr_q.push_back(mon_exp);
                cur_hdr     = cur_hdr + 1'b1;
                pending_hdr = 0;
            end
            if (ready_encap_dfx) begin
                req_pulses++;
                pending_hdr = 1;
                tests_run++;
                if (prev_ready) begin
                    fail_cnt++;
                    $display("FAIL req_pulse: ready_encap_dfx high for 2+ cycles, required 1");
                end
            end
            prev_ready = ready_encap_dfx;
            if (prev_stall) begin
                stall_checks++;
                tests_run++;
                if (flit_valid !== 1'b1 || flit_data !== prev_data || flit_sop !== prev_sop || flit_eop !== prev_eop) begin
                    fail_cnt++;
                    $display("FAIL stall_hold: got v=%0b d=%h sop=%0b eop=%0b, required v=1 d=%h sop=%0b eop=%0b",
                             flit_valid, flit_data, flit_sop, flit_eop, prev_data, prev_sop, prev_eop);
                end
            end
            if (flit_valid && flit_ready) begin
                flits_seen++;
                tests_run++;
                if (phase == 0) begin
                    mon_exp = (hdr_q.size() > 0) ? hdr_q.pop_front() : '0;
                    if (flit_data !== mon_exp || flit_sop !== 1'b1 || flit_eop !== 1'b0) begin
                        fail_cnt++;
                        $display("FAIL hdr_flit: got d=%h sop=%0b eop=%0b, required d=%h sop=1 eop=0",
                                 flit_data, flit_sop, flit_eop, mon_exp);
                    end
                    phase = 1; beat = 0; csum = '0;
                end else if (phase == 1) begin
                    mon_exp = (pay_q.size() > 0) ? pay_q.pop_front() : '0;
`ifdef PKT_CHECKSUM_EN
                    mon_eop = 1'b0;
`else
                    mon_eop = (beat == PL - 1);
`endif
                    if (flit_data !== mon_exp || flit_sop !== 1'b0 || flit_eop !== mon_eop) begin
                        fail_cnt++;
                        $display("FAIL pay_flit[%0d]: got d=%h sop=%0b eop=%0b, required d=%h sop=0 eop=%0b",
                                 beat, flit_data, flit_sop, flit_eop, mon_exp, mon_eop);
                    end
                    csum = csum ^ mon_exp;
                    beat++;
                    if (beat == PL) begin
`ifdef PKT_CHECKSUM_EN
                        phase = 2;
`else
                        phase = 0;
`endif
                    end
                end else begin
                    last_trl = flit_data;
                    if (flit_data !== csum || flit_sop !== 1'b0 || flit_eop !== 1'b1) begin
                        fail_cnt++;
                        $display("FAIL trl_flit: got d=%h sop=%0b eop=%0b, required d=%h sop=0 eop=1",
                                 flit_data, flit_sop, flit_eop, csum);
                    end
                    phase = 0;
                end
            end
            prev_stall = flit_valid && !flit_ready;
            prev_data  = flit_data;
            prev_sop   = flit_sop;
            prev_eop   = flit_eop;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input bit accept);
        in_valid = 1'b1;
        in_data  = d;
        if (accept) pay_q.push_back(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        tests_run++;
        if (got !== req) begin
            fail_cnt++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; flit_ready = 1'b0; in_valid = 1'b0;
        pay_q.delete(); hdr_q.delete();
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_pkts(input int target, input int budget, input string name);
        int n = 0;
        while (pkt_sent != 16'(target) && n < budget) begin
            tick();
            n++;
        end
        tests_run++;
        if (pkt_sent !== 16'(target)) begin
            fail_cnt++;
            $display("FAIL %s: pkt_sent %0d after %0d cycles, required %0d", name, pkt_sent, n, target);
        end
    endtask

    task automatic wait_pay(input string name);
        int n = 0;
        while (!(flit_valid && !flit_sop) && n < 30) begin
            tick();
            n++;
        end
        tests_run++;
        if (!(flit_valid && !flit_sop)) begin
            fail_cnt++;
            $display("FAIL %s: payload phase not reached, valid=%0b sop=%0b", name, flit_valid, flit_sop);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        check("reset_ctrl", {59'd0, ready_encap_dfx, flit_valid, flit_sop, flit_eop, overflow}, 64'd0);
        check("reset_data", {12'd0, buf_count, pkt_sent, flit_data}, 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        $display("[TB] test_reset done");
    endtask

    task automatic test_basic();
        int base_req, base_flits;
        base_req = req_pulses; base_flits = flits_seen;
        cur_dst = 10'h2A5; cur_hdr = 9'h105; flit_ready = 1'b1;
        push(32'h11, 1); push(32'h22, 1); push(32'h33, 1); push(32'h44, 1);
        tick();
        check("req_cycle", {62'd0, ready_encap_dfx, flit_valid}, 64'h2);
        tick();
        check("wait_cycle", {62'd0, ready_encap_dfx, flit_valid}, 64'h0);
        tick();
        check("hdr_latency", {30'd0, flit_valid, flit_sop, flit_data}, {30'd0, 2'b11, 32'h0005_4B05});
        wait_pkts(1, 40, "basic_done");
        check("basic_req_pulses", 64'(req_pulses - base_req), 64'd1);
        check("basic_flits", 64'(flits_seen - base_flits), 64'(FLITS));
        check("basic_buf_empty", {60'd0, buf_count}, 64'd0);
        $display("[TB] test_basic done, pkt_sent=%0d", pkt_sent);
    endtask

    task automatic test_backpressure();
        bit pat [4];
        int base_stall, base_flits, n;
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
        base_stall = stall_checks; base_flits = flits_seen;
        cur_hdr = 9'h105; flit_ready = 1'b0;
        push(32'h11, 1); push(32'h22, 1); push(32'h33, 1); push(32'h44, 1);
        n = 0;
        while (pkt_sent != 16'd2 && n < 80) begin
            flit_ready = pat[n % 4];
            tick();
            n++;
        end
        flit_ready = 1'b1;
        check("bp_pkt_sent", 64'(pkt_sent), 64'd2);
        check("bp_flits", 64'(flits_seen - base_flits), 64'(FLITS));
        check("bp_stalls_seen", 64'(stall_checks > base_stall), 64'd1);
        check("bp_queues_empty", 64'(pay_q.size() + hdr_q.size()), 64'd0);
        $display("[TB] test_backpressure done, stall checks=%0d", stall_checks - base_stall);
    endtask

    task automatic test_overflow();
        flit_ready = 1'b0;
        for (int i = 0; i < 9; i++) push(32'h100 + i, i < 8);
        check("ovf_count", {60'd0, buf_count}, 64'd8);
        check("ovf_flag", {63'd0, overflow}, 64'd1);
        flit_ready = 1'b1;
        wait_pkts(4, 80, "ovf_drain");
        check("ovf_sticky", {63'd0, overflow}, 64'd1);
        check("ovf_buf_empty", {60'd0, buf_count}, 64'd0);
        check("ovf_queue_empty", 64'(pay_q.size()), 64'd0);
        do_reset();
        check("ovf_cleared", {63'd0, overflow}, 64'd0);
        $display("[TB] test_overflow done");
    endtask

    task automatic test_back_to_back();
        flit_ready = 1'b1;
        for (int i = 0; i < PL; i++) push(32'h200 + i, 1);
        wait_pay("b2b_pay");
        for (int i = 0; i < PL; i++) begin
            check("b2b_count_const", {60'd0, buf_count}, 64'(PL));
            push(32'h300 + i, 1);
        end
        check("b2b_count_after", {60'd0, buf_count}, 64'(PL));
        wait_pkts(2, 60, "b2b_done");
        check("b2b_buf_empty", {60'd0, buf_count}, 64'd0);
        $display("[TB] test_back_to_back done, pkt_sent=%0d", pkt_sent);
    endtask

    task automatic test_reset_mid();
        int base_req;
        flit_ready = 1'b1;
        for (int i = 0; i < PL; i++) push(32'h400 + i, 1);
        wait_pay("mid_pay");
        tick(); tick();
        rst_n = 1'b0;
        pay_q.delete(); hdr_q.delete();
        #1;
        check("mid_reset_ctrl", {60'd0, ready_encap_dfx, flit_valid, flit_sop, flit_eop}, 64'd0);
        check("mid_reset_data", {12'd0, buf_count, pkt_sent, flit_data}, 64'd0);
        base_req = req_pulses;
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < PL; i++) push(32'h500 + i, 1);
        wait_pkts(1, 40, "mid_next_pkt");
        check("mid_fresh_req", 64'(req_pulses - base_req), 64'd1);
        check("mid_queue_empty", 64'(pay_q.size()), 64'd0);
        $display("[TB] test_reset_mid done");
    endtask

`ifdef PKT_CHECKSUM_EN
    task automatic test_checksum();
        flit_ready = 1'b1;
        push(32'h0F, 1); push(32'hF0, 1); push(32'hFF, 1); push(32'h01, 1);
        wait_pkts(2, 40, "chk_done");
        check("chk_trailer", 64'(last_trl), 64'h1);
        $display("[TB] test_checksum done");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
`ifdef PKT_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
